// File: rtl/fpu_arb_pkg.sv
// Shared types and sizing for the FPU request arbiter.
package fpu_arb_pkg;

  localparam int unsigned ARB_NUM_REQ  = 4;
  localparam int unsigned FP_WIDTH     = 16;
  localparam int unsigned NUM_OPERANDS = 3;
  localparam int unsigned ARB_MAX_OUT  = 4;
  localparam int unsigned STATUS_W     = 5;

  typedef struct packed {
    logic [NUM_OPERANDS-1:0][FP_WIDTH-1:0] operands;
    logic [2:0]                            rnd_mode;
    logic [3:0]                            op;
    logic                                  op_mod;
    logic [2:0]                            src_fmt;
    logic [2:0]                            dst_fmt;
    logic [1:0]                            int_fmt;
    logic                                  vectorial_op;
  } fpu_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_req_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic          w_found;
  int unsigned   w_j;
  logic [IW-1:0] w_jidx;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    w_jidx  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_j    = (32'(i_ptr) + i) % N;
      w_jidx = IW'(w_j);
      if (i_en && !w_found && i_req[w_jidx]) begin
        w_found       = 1'b1;
        o_gnt[w_jidx] = 1'b1;
        o_idx         = w_jidx;
      end
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one FPU between NUM_REQ requesters: round-robin issue, tag-routed
// responses, bounded in-flight count and a one-cycle flush sequence.
module fpu_req_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ,
  parameter int unsigned MAX_OUT = ARB_MAX_OUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  fpu_req_t                   req_data_i [NUM_REQ],
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  input  logic [NUM_REQ-1:0]         rsp_ready_i,
  output logic [FP_WIDTH-1:0]        rsp_result_o,
  output logic [STATUS_W-1:0]        rsp_status_o,
  output logic                       fpu_in_valid_o,
  input  logic                       fpu_in_ready_i,
  output fpu_req_t                   fpu_req_o,
  output logic [$clog2(NUM_REQ)-1:0] fpu_tag_o,
  input  logic                       fpu_out_valid_i,
  output logic                       fpu_out_ready_o,
  input  logic [FP_WIDTH-1:0]        fpu_result_i,
  input  logic [STATUS_W-1:0]        fpu_status_i,
  input  logic [$clog2(NUM_REQ)-1:0] fpu_tag_i,
  output logic                       fpu_flush_o
);

  localparam int unsigned TAG_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [TAG_W-1:0]   r_grant;
  logic [TAG_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  fpu_req_t           r_bundle;

  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [TAG_W-1:0]   w_gnt_idx;
  logic               w_load;
  logic               w_in_hs;
  logic               w_out_hs;

  assign w_arb_en = (r_state == IDLE) && !flush_i && (r_cnt < CNT_W'(MAX_OUT));

  rr_arbiter #(.N(NUM_REQ), .IW(TAG_W)) u_rr (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  // Next state, issue handshake and response demux.
  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_in_hs         = 1'b0;
    req_ready_o     = '0;
    fpu_in_valid_o  = 1'b0;
    fpu_flush_o     = 1'b0;
    rsp_valid_o     = '0;
    fpu_out_ready_o = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (flush_i) begin
          w_state_nxt = FLUSH;
        end else if (|w_gnt) begin
          w_state_nxt = ISSUE;
          w_load      = 1'b1;
        end
      end
      ISSUE: begin
        // A same-cycle flush drops the op before the FPU can take it.
        if (flush_i) begin
          w_state_nxt = FLUSH;
        end else begin
          fpu_in_valid_o = 1'b1;
          if (fpu_in_ready_i) begin
            w_in_hs              = 1'b1;
            req_ready_o[r_grant] = 1'b1;
            w_state_nxt          = IDLE;
          end
        end
      end
      FLUSH: begin
        fpu_flush_o = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (r_state == FLUSH) begin
      fpu_out_ready_o = 1'b1;
    end else begin
      rsp_valid_o[fpu_tag_i] = fpu_out_valid_i;
      fpu_out_ready_o        = rsp_ready_i[fpu_tag_i];
    end
  end

  assign w_out_hs     = fpu_out_valid_i && fpu_out_ready_o;
  assign rsp_result_o = fpu_result_i;
  assign rsp_status_o = fpu_status_i;
  assign fpu_req_o    = r_bundle;
  assign fpu_tag_o    = r_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_bundle <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_grant  <= w_gnt_idx;
        r_bundle <= req_data_i[w_gnt_idx];
      end
      if (w_in_hs) begin
        r_ptr <= (r_grant == TAG_W'(NUM_REQ - 1)) ? '0 : r_grant + TAG_W'(1);
      end
      // In-flight count; simultaneous in and out handshakes cancel.
      if (r_state == FLUSH) begin
        r_cnt <= '0;
      end else if (w_in_hs && !w_out_hs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_in_hs && w_out_hs && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter: issue order, stall, credits, flush, reset.
module tb_fpu_req_arbiter;
  import fpu_arb_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush_i;
  logic [3:0]     req_valid_i;
  logic [3:0]     req_ready_o;
  fpu_req_t       data [4];
  logic [3:0]     rsp_valid_o;
  logic [3:0]     rsp_ready_i;
  logic [15:0]    rsp_result_o;
  logic [4:0]     rsp_status_o;
  logic           fpu_in_valid_o;
  logic           fpu_in_ready_i;
  fpu_req_t       fpu_req_o;
  logic [1:0]     fpu_tag_o;
  logic           fpu_out_valid_i;
  logic           fpu_out_ready_o;
  logic [15:0]    fpu_result_i;
  logic [4:0]     fpu_status_i;
  logic [1:0]     fpu_tag_i;
  logic           fpu_flush_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_req_arbiter dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(data),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_req_o(fpu_req_o), .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .fpu_tag_i(fpu_tag_i), .fpu_flush_o(fpu_flush_o)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_i = 1'b0; req_valid_i = '0; rsp_ready_i = '0; fpu_in_ready_i = 1'b0;
    fpu_out_valid_i = 1'b0; fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Waits for an issue handshake to be pending at the current sample point.
  task automatic wait_issue(output logic [1:0] tag, output bit ok);
    ok = 1'b0;
    tag = '0;
    for (int c = 0; c < 20; c++) begin
      if (fpu_in_valid_o && fpu_in_ready_i) begin
        tag = fpu_tag_o;
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic count_issues(input int cycles, output int n, output logic [1:0] first);
    n = 0;
    first = '0;
    for (int c = 0; c < cycles; c++) begin
      if (fpu_in_valid_o && fpu_in_ready_i) begin
        if (n == 0) first = fpu_tag_o;
        n++;
      end
      step();
    end
  endtask

  initial begin
    logic [1:0] t;
    bit         ok;
    int         n;

    for (int i = 0; i < 4; i++) begin
      data[i] = '0;
      data[i].operands[0] = 16'(16'h1000 + i);
      data[i].operands[1] = 16'(16'h2000 + i);
      data[i].operands[2] = 16'(16'h3000 + i);
      data[i].op          = 4'(i + 1);
      data[i].rnd_mode    = 3'(i);
    end

    @(negedge clk);
    do_reset();
    check("rst_in_valid", 128'(fpu_in_valid_o), 128'(0));
    check("rst_req_ready", 128'(req_ready_o), 128'(0));
    check("rst_flush", 128'(fpu_flush_o), 128'(0));
    check("rst_tag", 128'(fpu_tag_o), 128'(0));
    check("rst_req", 128'(fpu_req_o), 128'(0));

    // Single op from requester 0 and its result routed back.
    req_valid_i = 4'b0001;
    fpu_in_ready_i = 1'b1;
    check("t1_idle", 128'(fpu_in_valid_o), 128'(0));
    step();
    check("t1_in_valid", 128'(fpu_in_valid_o), 128'(1));
    check("t1_tag", 128'(fpu_tag_o), 128'(0));
    check("t1_req", 128'(fpu_req_o), 128'(data[0]));
    check("t1_ready", 128'(req_ready_o), 128'(4'b0001));
    req_valid_i = '0;
    step();
    check("t1_after", 128'(fpu_in_valid_o), 128'(0));
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; rsp_ready_i = 4'b0001;
    fpu_result_i = 16'h3c00; fpu_status_i = 5'b00001;
    #1;
    check("t1_rsp_valid", 128'(rsp_valid_o), 128'(4'b0001));
    check("t1_out_ready", 128'(fpu_out_ready_o), 128'(1));
    check("t1_result", 128'(rsp_result_o), 128'(16'h3c00));
    check("t1_status", 128'(rsp_status_o), 128'(5'b00001));
    fpu_tag_i = 2'd2; rsp_ready_i = 4'b0001;
    #1;
    check("t1_rsp_route2", 128'(rsp_valid_o), 128'(4'b0100));
    check("t1_bp", 128'(fpu_out_ready_o), 128'(0));
    step();
    fpu_out_valid_i = 1'b0;

    // Fairness with all four requesting.
    do_reset();
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; rsp_ready_i = 4'b1111;
    req_valid_i = 4'b1111; fpu_in_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_issue(t, ok);
      check("t2_timeout", 128'(ok), 128'(1));
      check("t2_tag", 128'(t), 128'(k % 4));
      check("t2_ready", 128'(req_ready_o), 128'(4'b0001 << (k % 4)));
      check("t2_req", 128'(fpu_req_o), 128'(data[k % 4]));
      step();
      if (k == 0) check("t2_gap", 128'(fpu_in_valid_o), 128'(0));
    end
    fpu_out_valid_i = 1'b0;

    // Stall on fpu_in_ready_i.
    do_reset();
    req_valid_i = 4'b0010; fpu_in_ready_i = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      check("t3_valid", 128'(fpu_in_valid_o), 128'(1));
      check("t3_tag", 128'(fpu_tag_o), 128'(1));
      check("t3_req", 128'(fpu_req_o), 128'(data[1]));
      check("t3_noready", 128'(req_ready_o), 128'(0));
      step();
    end
    fpu_in_ready_i = 1'b1;
    #1;
    check("t3_pulse", 128'(req_ready_o), 128'(4'b0010));
    step();
    req_valid_i = '0;
    #1;
    check("t3_pulse_end", 128'(req_ready_o), 128'(0));
    check("t3_in_valid_end", 128'(fpu_in_valid_o), 128'(0));

    // Credit limit and simultaneous in/out handshakes.
    do_reset();
    req_valid_i = 4'b1111; fpu_in_ready_i = 1'b1;
    count_issues(20, n, t);
    check("t4_fill", 128'(n), 128'(4));
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; rsp_ready_i = 4'b1111;
    #1;
    check("t4_rsp_valid", 128'(rsp_valid_o), 128'(4'b0001));
    check("t4_out_ready", 128'(fpu_out_ready_o), 128'(1));
    step();
    fpu_out_valid_i = 1'b0; fpu_in_ready_i = 1'b0;
    step();
    check("t4_reissue", 128'(fpu_in_valid_o), 128'(1));
    check("t4_reissue_tag", 128'(fpu_tag_o), 128'(0));
    fpu_in_ready_i = 1'b1; fpu_out_valid_i = 1'b1;
    step();
    fpu_out_valid_i = 1'b0;
    count_issues(20, n, t);
    check("t4_one_more", 128'(n), 128'(1));

    // Flush while an op is in ISSUE with three in flight.
    do_reset();
    req_valid_i = 4'b1111; fpu_in_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_issue(t, ok);
      check("t5_pre_timeout", 128'(ok), 128'(1));
      step();
    end
    fpu_in_ready_i = 1'b0;
    step();
    check("t5_issue", 128'(fpu_in_valid_o), 128'(1));
    check("t5_issue_tag", 128'(fpu_tag_o), 128'(3));
    flush_i = 1'b1; fpu_in_ready_i = 1'b1;
    #1;
    check("t5_drop_ready", 128'(req_ready_o), 128'(0));
    step();
    flush_i = 1'b0; fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd1; rsp_ready_i = 4'b0000;
    #1;
    check("t5_flush", 128'(fpu_flush_o), 128'(1));
    check("t5_drain", 128'(fpu_out_ready_o), 128'(1));
    check("t5_rsp_quiet", 128'(rsp_valid_o), 128'(0));
    check("t5_no_ready", 128'(req_ready_o), 128'(0));
    check("t5_no_valid", 128'(fpu_in_valid_o), 128'(0));
    step();
    fpu_out_valid_i = 1'b0;
    check("t5_flush_once", 128'(fpu_flush_o), 128'(0));
    count_issues(20, n, t);
    check("t5_credits", 128'(n), 128'(4));
    check("t5_first_tag", 128'(t), 128'(3));

    // Asynchronous reset while in ISSUE.
    do_reset();
    req_valid_i = 4'b0001; fpu_in_ready_i = 1'b1;
    wait_issue(t, ok);
    check("t6_pre", 128'(ok), 128'(1));
    step();
    req_valid_i = 4'b1111; fpu_in_ready_i = 1'b0;
    step();
    check("t6_issue", 128'(fpu_in_valid_o), 128'(1));
    check("t6_issue_tag", 128'(fpu_tag_o), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", 128'(fpu_in_valid_o), 128'(0));
    check("t6_async_tag", 128'(fpu_tag_o), 128'(0));
    check("t6_async_req", 128'(fpu_req_o), 128'(0));
    check("t6_async_ready", 128'(req_ready_o), 128'(0));
    check("t6_async_flush", 128'(fpu_flush_o), 128'(0));
    @(negedge clk);
    rst = 1'b0; fpu_in_ready_i = 1'b1;
    wait_issue(t, ok);
    check("t6_post_timeout", 128'(ok), 128'(1));
    check("t6_ptr_zero", 128'(t), 128'(0));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
